// File: rtl/program_loader.sv
// Host byte stream -> program memory writer; holds the CPU while loading. LO byte accepted at edge k -> write strobe in cycle k+1.
// Backpressure via rx_ready (LEN/HI/LO/CHK only). Trailing XOR checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int PROGRAM_DataWidth = 16,
    parameter int PC_WIDTH          = 8,
    parameter int ByteWidth         = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [ByteWidth-1:0]         rx_data_i,
    input  logic                         rx_valid_i,
    output logic                         rx_ready_o,
    output logic [PC_WIDTH-1:0]          prog_adr_o,
    output logic [PROGRAM_DataWidth-1:0] prog_data_o,
    output logic                         prog_wr_en_o,
    output logic                         cpu_hold_o,
    output logic                         done_o,
    output logic                         error_o
);

    localparam int CW = PC_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                         state_q, state_d;
    logic [PC_WIDTH-1:0]            adr_q, adr_d;
    logic [PROGRAM_DataWidth-1:0]   data_q, data_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [CW-1:0]                  total_q, total_d;
    logic                           hold_q, hold_d;
    logic                           done_q, done_d;
    logic                           xfer;
    logic                           start_ok;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [ByteWidth-1:0]           chk_q, chk_d;
    logic                           error_q, error_d;
`endif

    assign rx_ready_o   = (state_q == S_LEN) || (state_q == S_HI) ||
                          (state_q == S_LO)  || (state_q == S_CHK);
    assign xfer         = rx_valid_i & rx_ready_o;
    assign start_ok     = start_i & ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                     (state_q == S_ERR));
    assign prog_wr_en_o = (state_q == S_WRITE);
    assign prog_adr_o   = adr_q;
    assign prog_data_o  = data_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign error_o      = error_q;
`else
    assign error_o      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        hold_d  = hold_q;
        done_d  = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
        error_d = error_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) begin
                    state_d = S_LEN;
                    adr_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    hold_d  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = '0;
                    error_d = 1'b0;
`endif
                end
            end
            S_LEN: begin
                if (xfer) begin
                    // A zero length byte means a full memory image.
                    total_d = (rx_data_i == '0) ? (CW'(1) << PC_WIDTH) : CW'(rx_data_i);
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    data_d[PROGRAM_DataWidth-1 -: ByteWidth] = rx_data_i;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data_i;
`endif
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    data_d[ByteWidth-1:0] = rx_data_i;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data_i;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                adr_d = adr_q + PC_WIDTH'(1);
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == total_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    // A bad checksum leaves the CPU stalled until a good load.
                    if (rx_data_i == chk_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q   <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
            error_q <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a word-list model of the load protocol.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  prog_adr;
    logic [15:0] prog_data;
    logic        prog_wr_en;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int passes = 0;

    logic [15:0] words [0:255];
    logic [7:0]  wq_adr [$];
    logic [15:0] wq_dat [$];

    program_loader #(.PROGRAM_DataWidth(16), .PC_WIDTH(8), .ByteWidth(8)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .prog_adr_o(prog_adr), .prog_data_o(prog_data), .prog_wr_en_o(prog_wr_en),
        .cpu_hold_o(cpu_hold), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_wr_en === 1'b1) begin
            wq_adr.push_back(prog_adr);
            wq_dat.push_back(prog_data);
        end
    end

    function automatic logic [7:0] model_chk(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ words[i][15:8] ^ words[i][7:0];
        return x;
    endfunction

    // All stimulus tasks are entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        rx_valid = 1'b0;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            $display("FAIL rx_ready_timeout got %b want 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        wq_adr.delete();
        wq_dat.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1 && error !== 1'b1) begin
            checks++;
            $display("FAIL end_timeout done=%b error=%b want one set", done, error);
        end
    endtask

    task automatic gap_of(input int gmax, output int g);
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    endtask

    task automatic run_load(input int n, input int gmax, input logic [7:0] chk_flip);
        int g;
        pulse_start();
        gap_of(gmax, g); send_byte(8'(n), g);
        for (int i = 0; i < n; i++) begin
            gap_of(gmax, g); send_byte(words[i][15:8], g);
            gap_of(gmax, g); send_byte(words[i][7:0], g);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        gap_of(gmax, g); send_byte(model_chk(n) ^ chk_flip, g);
`else
        if (chk_flip != 8'h00) g = 0;
`endif
        wait_end();
    endtask

    task automatic test_reset();
        checks++; if (rx_ready !== 1'b0)    $display("FAIL reset_rx_ready got %b want 0", rx_ready);    else passes++;
        checks++; if (prog_adr !== 8'h00)   $display("FAIL reset_prog_adr got %h want 00", prog_adr);   else passes++;
        checks++; if (prog_data !== 16'h0)  $display("FAIL reset_prog_data got %h want 0", prog_data);  else passes++;
        checks++; if (prog_wr_en !== 1'b0)  $display("FAIL reset_wr_en got %b want 0", prog_wr_en);     else passes++;
        checks++; if (cpu_hold !== 1'b0)    $display("FAIL reset_cpu_hold got %b want 0", cpu_hold);    else passes++;
        checks++; if (done !== 1'b0)        $display("FAIL reset_done got %b want 0", done);            else passes++;
        checks++; if (error !== 1'b0)       $display("FAIL reset_error got %b want 0", error);          else passes++;
    endtask

    task automatic test_basic(input int gmax, input string tag);
        int bad = 0;
        words[0] = 16'h0890;
        words[1] = 16'h4805;
        run_load(2, gmax, 8'h00);
        for (int i = 0; i < wq_adr.size() && i < 2; i++)
            if (wq_adr[i] !== 8'(i) || wq_dat[i] !== words[i]) bad++;
        checks++; if (wq_adr.size() != 2) $display("FAIL %s_wr_pulses got %0d want 2", tag, wq_adr.size()); else passes++;
        checks++; if (bad != 0)           $display("FAIL %s_words got %0d bad want 0", tag, bad);           else passes++;
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0)
            $display("FAIL %s_status got d%b h%b e%b want d1 h0 e0", tag, done, cpu_hold, error); else passes++;
        checks++; if (prog_adr !== 8'h02) $display("FAIL %s_final_adr got %h want 02", tag, prog_adr); else passes++;
    endtask

    task automatic test_latency();
        pulse_start();
        checks++; if (done !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL start_clears got d%b h%b want d0 h1", done, cpu_hold); else passes++;
        words[0] = 16'h1234;
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        checks++; if (prog_wr_en !== 1'b1 || prog_adr !== 8'h00 || prog_data !== 16'h1234 || rx_ready !== 1'b0)
            $display("FAIL latency_write got we%b a%h d%h r%b want we1 a00 d1234 r0",
                     prog_wr_en, prog_adr, prog_data, rx_ready); else passes++;
        @(negedge clk);
        checks++; if (prog_wr_en !== 1'b0) $display("FAIL strobe_width got %b want 0", prog_wr_en); else passes++;
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h26, 0);
`endif
        wait_end();
        checks++; if (done !== 1'b1) $display("FAIL latency_done got %b want 1", done); else passes++;
    endtask

    task automatic test_checksum();
        words[0] = 16'h1234;
        run_load(1, 0, 8'h26);
        checks++; if (wq_adr.size() != 1 || wq_dat[0] !== 16'h1234)
            $display("FAIL chk_bad_write got %0d writes want 1 of 1234", wq_adr.size()); else passes++;
        checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL chk_bad_status got e%b d%b h%b want e1 d0 h1", error, done, cpu_hold); else passes++;
        run_load(1, 2, 8'h00);
        checks++; if (error !== 1'b0 || done !== 1'b1 || cpu_hold !== 1'b0)
            $display("FAIL chk_good_status got e%b d%b h%b want e0 d1 h0", error, done, cpu_hold); else passes++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n = int'($urandom_range(20, 1));
            int bad = 0;
            for (int i = 0; i < n; i++) words[i] = 16'($urandom);
            run_load(n, 3, 8'h00);
            for (int i = 0; i < wq_adr.size() && i < n; i++)
                if (wq_adr[i] !== 8'(i) || wq_dat[i] !== words[i]) bad++;
            checks++; if (wq_adr.size() != n || bad != 0)
                $display("FAIL rand_words got %0d writes %0d bad want %0d writes 0 bad", wq_adr.size(), bad, n); else passes++;
            checks++; if (done !== 1'b1 || prog_adr !== 8'(n))
                $display("FAIL rand_end got d%b a%h want d1 a%h", done, prog_adr, 8'(n)); else passes++;
        end
    endtask

    task automatic test_full();
        int bad = 0;
        for (int i = 0; i < 256; i++) words[i] = 16'(i);
        run_load(256, 0, 8'h00);
        for (int i = 0; i < wq_adr.size() && i < 256; i++)
            if (wq_adr[i] !== 8'(i) || wq_dat[i] !== words[i]) bad++;
        checks++; if (wq_adr.size() != 256 || bad != 0)
            $display("FAIL full_words got %0d writes %0d bad want 256 writes 0 bad", wq_adr.size(), bad); else passes++;
        checks++; if (wq_adr.size() == 256 && (wq_adr[255] !== 8'hFF || wq_dat[255] !== 16'h00FF))
            $display("FAIL full_last got a%h d%h want aFF d00FF", wq_adr[255], wq_dat[255]); else passes++;
        checks++; if (done !== 1'b1 || prog_adr !== 8'h00)
            $display("FAIL full_end got d%b a%h want d1 a00", done, prog_adr); else passes++;
    endtask

    task automatic test_reset_midload();
        int bad = 0;
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hEF, 1);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        words[0] = 16'($urandom);
        words[1] = 16'($urandom);
        run_load(2, 1, 8'h00);
        for (int i = 0; i < wq_adr.size() && i < 2; i++)
            if (wq_adr[i] !== 8'(i) || wq_dat[i] !== words[i]) bad++;
        checks++; if (wq_adr.size() != 2 || bad != 0 || done !== 1'b1)
            $display("FAIL post_reset_load got %0d writes %0d bad d%b want 2 0 d1", wq_adr.size(), bad, done); else passes++;
    endtask

    task automatic test_start_ignored();
        int bad = 0;
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(words[0][15:8], 0);
        send_byte(words[0][7:0], 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (prog_adr !== 8'h01 || rx_ready !== 1'b1)
            $display("FAIL start_ign_adr got a%h r%b want a01 r1", prog_adr, rx_ready); else passes++;
        for (int i = 1; i < 3; i++) begin
            send_byte(words[i][15:8], 0);
            send_byte(words[i][7:0], 0);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(model_chk(3), 0);
`endif
        wait_end();
        for (int i = 0; i < wq_adr.size() && i < 3; i++)
            if (wq_adr[i] !== 8'(i) || wq_dat[i] !== words[i]) bad++;
        checks++; if (wq_adr.size() != 3 || bad != 0 || done !== 1'b1 || prog_adr !== 8'h03)
            $display("FAIL start_ign_load got %0d writes %0d bad d%b a%h want 3 0 d1 a03",
                     wq_adr.size(), bad, done, prog_adr); else passes++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic(0, "basic");
        test_basic(5, "gaps");
        test_latency();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        test_full();
        test_reset_midload();
        test_start_ignored();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
